// File: rtl/vip_flow_control_output_buffered_if.sv
// Core-side write/stall, encoder-side ready/valid and control-packet signals of the
// buffered output flow-control stage.
interface vip_flow_control_output_buffered_if #(
  parameter int unsigned DW = 24,
  parameter int unsigned LW = 3
);
  logic [DW-1:0] data_in;
  logic          end_of_video_in;
  logic          write;
  logic          stall_out;
  logic [15:0]   ctrl_width_in;
  logic [15:0]   ctrl_height_in;
  logic [3:0]    ctrl_interlaced_in;
  logic          ctrl_valid_in;
  logic          dout_ready;
  logic          dout_valid;
  logic [DW-1:0] dout_data;
  logic          encoder_end_of_video;
  logic [15:0]   encoder_width;
  logic [15:0]   encoder_height;
  logic [3:0]    encoder_interlaced;
  logic          encoder_vip_ctrl_send;
  logic          encoder_vip_ctrl_busy;
  logic [LW-1:0] fill_level;
  logic          overflow;

  modport slave (
    input  data_in, end_of_video_in, write, ctrl_width_in, ctrl_height_in,
           ctrl_interlaced_in, ctrl_valid_in, dout_ready, encoder_vip_ctrl_busy,
    output stall_out, dout_valid, dout_data, encoder_end_of_video, encoder_width,
           encoder_height, encoder_interlaced, encoder_vip_ctrl_send, fill_level, overflow
  );

  modport master (
    output data_in, end_of_video_in, write, ctrl_width_in, ctrl_height_in,
           ctrl_interlaced_in, ctrl_valid_in, dout_ready, encoder_vip_ctrl_busy,
    input  stall_out, dout_valid, dout_data, encoder_end_of_video, encoder_width,
           encoder_height, encoder_interlaced, encoder_vip_ctrl_send, fill_level, overflow
  );
endinterface

// File: rtl/vip_flow_control_output_buffered.sv
// Buffered output flow control: write/stall to ready/valid FIFO plus control-packet geometry.
// Define VIP_FCO_CTRL_SYNC_EN to hold control sends until all buffered beats have drained.
module vip_flow_control_output_buffered #(
  parameter int unsigned BITS_PER_SYMBOL    = 8,
  parameter int unsigned SYMBOLS_PER_BEAT   = 3,
  parameter int unsigned PIXELS_IN_PARALLEL = 1,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter logic [15:0] WIDTH_DEFAULT      = 16'd640,
  parameter logic [15:0] HEIGHT_DEFAULT     = 16'd480,
  parameter logic [3:0]  INTERLACED_DEFAULT = 4'd0
) (
  input logic                               clk,
  input logic                               rst,
  vip_flow_control_output_buffered_if.slave bus
);

  localparam int unsigned DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT * PIXELS_IN_PARALLEL;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLevel  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] StallLevel = LW'(FIFO_DEPTH - 1);

  logic [DW:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic          stall_q, overflow_q, overflow_d;
  logic          valid, full, push, pop;
  logic [DW:0]   head;

  logic [15:0]   width_q, height_q;
  logic [3:0]    interlaced_q;
  logic          pending_q, pending_d;
  logic          sync_ok, send;

  assign valid = (count_q != '0);
  assign full  = (count_q == FullLevel);
  assign pop   = valid & bus.dout_ready;
  // A pop in the same cycle frees the slot, so a write while full is still accepted.
  assign push  = bus.write & (~full | pop);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    count_d    = count_q + LW'(push) - LW'(pop);
    overflow_d = overflow_q | (bus.write & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.end_of_video_in, bus.data_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      // One entry of slack covers the core's one-cycle stall response.
      stall_q    <= (count_d >= StallLevel);
      overflow_q <= overflow_d;
    end
  end

  assign bus.stall_out            = stall_q;
  assign bus.dout_valid           = valid;
  assign bus.dout_data            = valid ? head[DW-1:0] : '0;
  assign bus.encoder_end_of_video = valid & head[DW];
  assign bus.fill_level           = count_q;
  assign bus.overflow             = overflow_q;

`ifdef VIP_FCO_CTRL_SYNC_EN
  assign sync_ok = (count_q == '0) & ~bus.write;
`else
  assign sync_ok = 1'b1;
`endif

  assign send = pending_q & ~bus.encoder_vip_ctrl_busy & sync_ok;

  // A fresh update in the send cycle keeps the request alive for a second send.
  always_comb begin
    pending_d = bus.ctrl_valid_in | (pending_q & ~send);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q      <= WIDTH_DEFAULT;
      height_q     <= HEIGHT_DEFAULT;
      interlaced_q <= INTERLACED_DEFAULT;
      pending_q    <= 1'b0;
    end else begin
      if (bus.ctrl_valid_in) begin
        width_q      <= bus.ctrl_width_in;
        height_q     <= bus.ctrl_height_in;
        interlaced_q <= bus.ctrl_interlaced_in;
      end
      pending_q <= pending_d;
    end
  end

  assign bus.encoder_width         = width_q;
  assign bus.encoder_height        = height_q;
  assign bus.encoder_interlaced    = interlaced_q;
  assign bus.encoder_vip_ctrl_send = send;

endmodule

// File: doc/vip_flow_control_output_buffered.md
# vip_flow_control_output_buffered

Buffered, parametrised output flow-control stage for the clocked-video output path. It sits between the algorithm core and the video encoder. It converts the core's write/stall protocol to the encoder's ready/valid protocol through a FIFO with registered stall and end-of-video tagging, and supports multiple pixels in parallel. It also holds control-packet geometry (width/height/interlaced) in registers and issues a single send request per update to the encoder, with optional ordering against buffered data.

## Interface
- BITS_PER_SYMBOL, 8, bits per colour symbol
- SYMBOLS_PER_BEAT, 3, symbols per pixel
- PIXELS_IN_PARALLEL, 1, pixels per beat; DW = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT*PIXELS_IN_PARALLEL
- FIFO_DEPTH, 4, data FIFO entries; power of two, >= 4
- WIDTH_DEFAULT, 16'd640, reset width
- HEIGHT_DEFAULT, 16'd480, reset height
- INTERLACED_DEFAULT, 4'd0, reset interlaced code

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- data_in  in  DW  beat from core
- end_of_video_in  in  1  tag stored with beat
- write  in  1  core write strobe
- stall_out  out  1  registered stall to core
- ctrl_width_in / ctrl_height_in  in  16  new geometry
- ctrl_interlaced_in  in  4  new interlaced code
- ctrl_valid_in  in  1  geometry update strobe
- dout_ready  in  1  encoder ready
- dout_valid  out  1  head beat valid
- dout_data  out  DW  head beat data
- encoder_end_of_video  out  1  head beat tag
- encoder_width / encoder_height  out  16  registered geometry
- encoder_interlaced  out  4  registered interlaced code
- encoder_vip_ctrl_send  out  1  control-packet send request
- encoder_vip_ctrl_busy  in  1  encoder busy with control packet
- fill_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: write dropped while full

## Operation
- FIFO entry = {end_of_video_in, data_in}. Pointers wrap modulo FIFO_DEPTH. fill_level is a separate counter.
- push = write & (fill_level != FIFO_DEPTH | pop). pop = dout_valid & dout_ready. Simultaneous push and pop leave the count unchanged, including when the FIFO is full or holds one entry.
- A write while full without a pop is dropped and sets overflow. overflow clears only on rst.
- Show-ahead output: dout_valid = (fill_level != 0). dout_data and encoder_end_of_video present the head entry.
- stall_out register takes the value (next fill_level >= FIFO_DEPTH-1). This gives one beat of slack for the core's one-cycle stall response.
- Control state: width_reg, height_reg, interlaced_reg, pending.
  - On ctrl_valid_in, load all three regs from the inputs and set pending. encoder_* outputs drive the regs directly.
  - encoder_vip_ctrl_send = pending & ~encoder_vip_ctrl_busy & sync_ok. Without the sync macro, sync_ok = 1.
  - pending clears on any cycle where send is high, unless ctrl_valid_in is also high that cycle. In that case the new values load and pending stays set, so a second send follows.
  - ctrl_valid_in while pending and not yet sent: latest values overwrite the previous ones and only one send is issued.

## Timing
- Reset values: stall_out 0, dout_valid 0, fill_level 0, overflow 0, encoder_vip_ctrl_send 0, encoder_end_of_video 0. encoder_width/height/interlaced take the *_DEFAULT values. Pointers are 0.
- write at edge N: dout_valid high after edge N (cycle N+1). Data latency is 1 cycle.
- ctrl_valid_in at edge N: encoder_width/height/interlaced change after edge N. send is high in cycle N+1 if busy=0.
- send is combinational from pending and busy. It is a one-cycle pulse per update when busy is low.
- rst mid-frame discards FIFO contents and any pending send immediately.

## Configuration
- VIP_FCO_CTRL_SYNC_EN
  - Defined: sync_ok = (fill_level == 0) & ~write. A pending control send is withheld until all previously buffered beats have left. Geometry registers still update immediately.
  - Undefined: sync_ok = 1, and send is independent of data.

## Test plan
- Reset: assert rst asynchronously mid-burst. Required: all outputs immediately at reset values; encoder_width = 640, height = 480.
- Fill to full: FIFO_DEPTH=4, dout_ready=0, 5 writes. Required: stall_out high after the 3rd write, fill_level=4, 5th write dropped, overflow=1. Draining then returns beats 1-4 in order with tags intact.
- Full with simultaneous push and pop: fill_level=4, write & dout_ready same cycle. Required: fill_level stays 4, overflow stays 0, order preserved.
- Control with busy: ctrl_valid_in (1920,1080,0) while busy=1, then (1280,720,0) while busy=1, then busy drops. Required: exactly one send pulse, outputs 1280/720.
- Back-to-back control: ctrl_valid_in in the same cycle as a send. Required: a second send on the next non-busy cycle.
- Sync macro: with VIP_FCO_CTRL_SYNC_EN, 3 beats buffered, ctrl_valid_in, dout_ready=1. Required: send asserted only in the cycle after the last pop. Without the macro, send is asserted in the cycle after ctrl_valid_in.
